// File: rtl/alu_out_stage.sv
// 4-bit add/subtract ALU with a registered result and flags, feeding a one-entry output register.
// lo and eu both act with 1-cycle latency; a lo while the output is full and unaccepted is dropped and sets a sticky overrun flag.
module alu_out_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic       lb,
  input  logic       su,
  input  logic       eu,
  input  logic       lo,
  input  logic       out_ready,
  input  logic       ovr_clr,
  output logic [3:0] alu_out,
  output logic       carry,
  output logic       zero,
  output logic [3:0] out_data,
  output logic       out_valid,
  output logic       overrun,
  output logic [7:0] out_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] b_q, b_d;
  logic [3:0] alu_q, alu_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic [3:0] data_q, data_d;
  logic       ovr_q, ovr_d;
  logic [7:0] count_q, count_d;

  logic [4:0] operand_b;
  logic [4:0] sum;
  logic       ovr_set;

  // Subtract is A + ~B + 1, so carry doubles as "no borrow".
  assign operand_b = su ? ({1'b0, ~b_q} + 5'd1) : {1'b0, b_q};
  assign sum       = {1'b0, a_in} + operand_b;

  always_comb begin
    b_d     = b_q;
    alu_d   = alu_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (lb) begin
      b_d = b_in;
    end
    if (eu) begin
      alu_d   = sum[3:0];
      carry_d = sum[4];
      zero_d  = (sum[3:0] == 4'd0);
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    ovr_set = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (lo) begin
          data_d  = a_in;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          count_d = count_q + 8'd1;
          if (lo) begin
            data_d = a_in;
          end else begin
            state_d = EMPTY;
          end
        end else if (lo) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A fresh overrun outranks a clear in the same cycle.
    ovr_d = ovr_set | (ovr_q & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      b_q     <= 4'd0;
      alu_q   <= 4'd0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      data_q  <= 4'd0;
      ovr_q   <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      count_q <= count_d;
    end
  end

  assign alu_out   = alu_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign out_data  = data_q;
  assign out_valid = (state_q == FULL);
  assign overrun   = ovr_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_alu_out_stage.sv
// Directed bench for alu_out_stage: ALU add/sub and flags, output handshake, overrun, count wrap and async reset.
module tb_alu_out_stage;

  logic       clk;
  logic       reset;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       lb;
  logic       su;
  logic       eu;
  logic       lo;
  logic       out_ready;
  logic       ovr_clr;
  logic [3:0] alu_out;
  logic       carry;
  logic       zero;
  logic [3:0] out_data;
  logic       out_valid;
  logic       overrun;
  logic [7:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_out_stage dut (
    .clk       (clk),
    .reset     (reset),
    .a_in      (a_in),
    .b_in      (b_in),
    .lb        (lb),
    .su        (su),
    .eu        (eu),
    .lo        (lo),
    .out_ready (out_ready),
    .ovr_clr   (ovr_clr),
    .alu_out   (alu_out),
    .carry     (carry),
    .zero      (zero),
    .out_data  (out_data),
    .out_valid (out_valid),
    .overrun   (overrun),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_alu"},   {4'd0, alu_out}, 8'h00);
    check_eq({tag, "_carry"}, {7'd0, carry},   8'h00);
    check_eq({tag, "_zero"},  {7'd0, zero},    8'h00);
    check_eq({tag, "_data"},  {4'd0, out_data}, 8'h00);
    check_eq({tag, "_valid"}, {7'd0, out_valid}, 8'h00);
    check_eq({tag, "_ovr"},   {7'd0, overrun}, 8'h00);
    check_eq({tag, "_count"}, out_count,       8'h00);
  endtask

  initial begin
    reset = 1'b0; a_in = 4'd0; b_in = 4'd0;
    lb = 1'b0; su = 1'b0; eu = 1'b0; lo = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0;
    #1;
    check_all_zero("rst");
    step();
    reset = 1'b1;

    // Add: 0xA + 0x5 = 0xF, then 0xA + 0x9 = 0x13
    lb = 1'b1; b_in = 4'h5; step(); lb = 1'b0;
    a_in = 4'hA; su = 1'b0; eu = 1'b1; step(); eu = 1'b0;
    check_eq("add_f_alu",   {4'd0, alu_out}, 8'h0F);
    check_eq("add_f_carry", {7'd0, carry},   8'h00);
    check_eq("add_f_zero",  {7'd0, zero},    8'h00);
    lb = 1'b1; b_in = 4'h9; step(); lb = 1'b0;
    eu = 1'b1; step(); eu = 1'b0;
    check_eq("add_3_alu",   {4'd0, alu_out}, 8'h03);
    check_eq("add_3_carry", {7'd0, carry},   8'h01);
    a_in = 4'h1; step();
    check_eq("alu_hold", {4'd0, alu_out}, 8'h03);

    // Subtract: 5-5 = 0 no borrow, 3-5 = 0xE borrow
    lb = 1'b1; b_in = 4'h5; step(); lb = 1'b0;
    a_in = 4'h5; su = 1'b1; eu = 1'b1; step();
    check_eq("sub0_alu",   {4'd0, alu_out}, 8'h00);
    check_eq("sub0_zero",  {7'd0, zero},    8'h01);
    check_eq("sub0_carry", {7'd0, carry},   8'h01);
    a_in = 4'h3; step(); eu = 1'b0;
    check_eq("subE_alu",   {4'd0, alu_out}, 8'h0E);
    check_eq("subE_carry", {7'd0, carry},   8'h00);
    check_eq("subE_zero",  {7'd0, zero},    8'h00);

    // lb with eu: old B (5) used now, new B (1) next cycle
    su = 1'b0; a_in = 4'h3; lb = 1'b1; b_in = 4'h1; eu = 1'b1; step(); lb = 1'b0;
    check_eq("lbeu_old", {4'd0, alu_out}, 8'h08);
    step(); eu = 1'b0;
    check_eq("lbeu_new", {4'd0, alu_out}, 8'h04);

    // Output handshake, stall, overrun, transfer, clear
    lo = 1'b1; a_in = 4'h3; out_ready = 1'b0; step(); lo = 1'b0;
    check_eq("lo_valid", {7'd0, out_valid}, 8'h01);
    check_eq("lo_data",  {4'd0, out_data},  8'h03);
    a_in = 4'hC; step(); step();
    check_eq("stall_data",  {4'd0, out_data},  8'h03);
    check_eq("stall_valid", {7'd0, out_valid}, 8'h01);
    check_eq("stall_count", out_count, 8'h00);
    lo = 1'b1; a_in = 4'h7; step(); lo = 1'b0;
    check_eq("ovr_set",  {7'd0, overrun},  8'h01);
    check_eq("ovr_data", {4'd0, out_data}, 8'h03);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check_eq("xfer_valid", {7'd0, out_valid}, 8'h00);
    check_eq("xfer_count", out_count, 8'h01);
    check_eq("ovr_sticky", {7'd0, overrun}, 8'h01);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check_eq("empty_ready_count", out_count, 8'h01);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    check_eq("ovr_clr", {7'd0, overrun}, 8'h00);

    // Back-to-back: load while transferring
    lo = 1'b1; a_in = 4'h3; step();
    a_in = 4'h8; out_ready = 1'b1; step(); lo = 1'b0;
    check_eq("b2b_data",  {4'd0, out_data},  8'h08);
    check_eq("b2b_valid", {7'd0, out_valid}, 8'h01);
    check_eq("b2b_count", out_count, 8'h02);
    step(); out_ready = 1'b0;
    check_eq("drain_valid", {7'd0, out_valid}, 8'h00);
    check_eq("drain_data",  {4'd0, out_data},  8'h08);
    check_eq("drain_count", out_count, 8'h03);

    // Overrun set wins over clear
    lo = 1'b1; a_in = 4'h1; step();
    a_in = 4'h2; ovr_clr = 1'b1; step(); lo = 1'b0;
    check_eq("set_wins", {7'd0, overrun},  8'h01);
    check_eq("set_data", {4'd0, out_data}, 8'h01);
    step(); ovr_clr = 1'b0;
    check_eq("clr_after", {7'd0, overrun}, 8'h00);
    lo = 1'b1; step(); lo = 1'b0;
    check_eq("ovr_again", {7'd0, overrun}, 8'h01);

    // Async reset mid-cycle while FULL with non-zero state
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("mid_rst");
    step();
    reset = 1'b1;
    step();
    check_eq("post_rst_count", out_count, 8'h00);
    check_eq("post_rst_valid", {7'd0, out_valid}, 8'h00);

    // Count wrap: one fill cycle, then a transfer every cycle
    lo = 1'b1; out_ready = 1'b1; a_in = 4'h6;
    repeat (256) step();
    check_eq("cnt_ff", out_count, 8'hFF);
    step();
    check_eq("cnt_wrap", out_count, 8'h00);
    step();
    check_eq("cnt_01", out_count, 8'h01);
    check_eq("cnt_no_ovr", {7'd0, overrun}, 8'h00);
    lo = 1'b0; out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
